// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V controller: opcodes, FSM states,
// ALU-op / write-back select codes and trap causes.
package riscv_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] IMM    = 7'b0010011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] HALT   = 7'b0000000;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;
    localparam logic [1:0] M2R_IMM = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode classifier: datapath selects, instruction class
// flags and legality (LUI/AUIPC legal only when SUPPORT_UPPER is set).
module ctrl_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int SUPPORT_UPPER = 1
) (
    input  logic [6:0] op,
    output logic       alu_src,
    output logic       alu_src_a,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jal,
    output logic       is_jalr,
    output logic       is_wb,
    output logic       is_halt,
    output logic       legal
);

    always_comb begin
        alu_src   = 1'b0;
        alu_src_a = 1'b0;
        alu_op    = ALUOP_ADD;
        wb_sel    = M2R_ALU;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_wb     = 1'b0;
        is_halt   = 1'b0;
        legal     = 1'b0;
        case (op)
            R_TYPE: begin
                legal  = 1'b1;
                alu_op = ALUOP_RTYPE;
                is_wb  = 1'b1;
            end
            LW: begin
                legal   = 1'b1;
                alu_src = 1'b1;
                is_load = 1'b1;
                wb_sel  = M2R_MEM;
            end
            SW: begin
                legal    = 1'b1;
                alu_src  = 1'b1;
                is_store = 1'b1;
            end
            BR: begin
                legal     = 1'b1;
                alu_op    = ALUOP_BRANCH;
                is_branch = 1'b1;
            end
            IMM: begin
                legal   = 1'b1;
                alu_src = 1'b1;
                alu_op  = ALUOP_ITYPE;
                is_wb   = 1'b1;
            end
            JAL: begin
                legal  = 1'b1;
                is_jal = 1'b1;
                wb_sel = M2R_PC4;
            end
            JALR: begin
                legal   = 1'b1;
                alu_src = 1'b1;
                alu_op  = ALUOP_ITYPE;
                is_jalr = 1'b1;
                wb_sel  = M2R_PC4;
            end
            // Upper-immediate forms decode fully either way; legal gates them
            LUI: begin
                legal  = (SUPPORT_UPPER != 0);
                is_wb  = 1'b1;
                wb_sel = M2R_IMM;
            end
            AUIPC: begin
                legal     = (SUPPORT_UPPER != 0);
                alu_src   = 1'b1;
                alu_src_a = 1'b1;
                is_wb     = 1'b1;
            end
            HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory ready
// handshakes, illegal-opcode and dmem-timeout traps, and a retired-instruction counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int SUPPORT_UPPER = 1,
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             dmem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             alu_src,
    output logic             alu_src_a,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             branch,
    output logic             jump,
    output logic             jumpr,
    output logic             halt,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t            state;
    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [6:0]        dec_op;

    logic       d_alu_src, d_alu_src_a, d_is_load, d_is_store, d_is_branch;
    logic       d_is_jal, d_is_jalr, d_is_wb, d_is_halt, d_legal;
    logic [1:0] d_alu_op, d_wb_sel;

    // op_q is only loaded at the end of DECODE, so DECODE classifies the live opcode
    assign dec_op  = (state == DECODE) ? opcode : op_q;
    assign state_o = state;

    ctrl_decode #(.SUPPORT_UPPER(SUPPORT_UPPER)) u_decode (
        .op        (dec_op),
        .alu_src   (d_alu_src),
        .alu_src_a (d_alu_src_a),
        .alu_op    (d_alu_op),
        .wb_sel    (d_wb_sel),
        .is_load   (d_is_load),
        .is_store  (d_is_store),
        .is_branch (d_is_branch),
        .is_jal    (d_is_jal),
        .is_jalr   (d_is_jalr),
        .is_wb     (d_is_wb),
        .is_halt   (d_is_halt),
        .legal     (d_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            op_q       <= '0;
            wait_cnt   <= '0;
            instret    <= '0;
            halt       <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            case (state)
                FETCH: if (imem_ready) state <= DECODE;
                DECODE: begin
                    op_q <= opcode;
                    if (d_is_halt) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (!d_legal) begin
                        state      <= TRAP;
                        halt       <= 1'b1;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (d_is_load || d_is_store) begin
                        state    <= MEM;
                        wait_cnt <= '0;
                    end else if (d_is_wb) begin
                        state <= WB;
                    end else begin
                        state   <= FETCH;
                        instret <= instret + CNT_W'(1);
                    end
                end
                // A ready arriving on the timeout cycle still completes the access
                MEM: begin
                    if (dmem_ready) begin
                        if (d_is_store) begin
                            state   <= FETCH;
                            instret <= instret + CNT_W'(1);
                        end else begin
                            state <= WB;
                        end
                    end else if (MEM_TIMEOUT > 0 && wait_cnt == WAIT_LAST) begin
                        state      <= TRAP;
                        halt       <= 1'b1;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                WB: begin
                    state   <= FETCH;
                    instret <= instret + CNT_W'(1);
                end
                HALTED, TRAP: state <= state;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        dmem_req   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_src_a  = 1'b0;
        mem_to_reg = M2R_ALU;
        alu_op     = ALUOP_ADD;
        branch     = 1'b0;
        jump       = 1'b0;
        jumpr      = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            EXEC: begin
                alu_src   = d_alu_src;
                alu_src_a = d_alu_src_a;
                alu_op    = d_alu_op;
                branch    = d_is_branch;
                jump      = d_is_jal;
                jumpr     = d_is_jalr;
                if (d_is_jal || d_is_jalr) begin
                    reg_write  = 1'b1;
                    mem_to_reg = d_wb_sel;
                end
            end
            MEM: begin
                dmem_req  = 1'b1;
                mem_read  = d_is_load;
                mem_write = d_is_store;
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = d_wb_sel;
                alu_src    = d_alu_src;
                alu_src_a  = d_alu_src_a;
                alu_op     = d_alu_op;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed scenarios plus randomized instruction streams
// compared cycle by cycle against a per-instruction phase model.
module tb_multicycle_controller;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write;
        logic       reg_write, alu_src, alu_src_a;
        logic [1:0] m2r, aop;
        logic       branch, jump, jumpr, halt, trap;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;

    logic       imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write, reg_write;
    logic       alu_src, alu_src_a, branch, jump, jumpr, halt, trap;
    logic [1:0] mem_to_reg, alu_op, trap_cause;
    logic [2:0] state_o;
    logic [3:0] instret;

    logic        imem_req2, ir_write2, pc_write2, dmem_req2, mem_read2, mem_write2, reg_write2;
    logic        alu_src2, alu_src_a2, branch2, jump2, jumpr2, halt2, trap2;
    logic [1:0]  mem_to_reg2, alu_op2, trap_cause2;
    logic [2:0]  state_o2;
    logic [31:0] instret2;

    ctl_t obs;
    int   checks = 0;
    int   failures = 0;
    int   model_ret = 0;

    logic [6:0] legal_ops [8] = '{OPC_R, OPC_LW, OPC_SW, OPC_BR, OPC_IMM, OPC_JAL, OPC_JALR, OPC_AUIPC};

    assign obs = {state_o, imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write,
                  reg_write, alu_src, alu_src_a, mem_to_reg, alu_op, branch, jump, jumpr,
                  halt, trap};

    always #5 clk = ~clk;

    multicycle_controller #(.SUPPORT_UPPER(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_write(ir_write),
        .pc_write(pc_write), .dmem_req(dmem_req), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src(alu_src),
        .alu_src_a(alu_src_a), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .branch(branch), .jump(jump), .jumpr(jumpr), .halt(halt), .trap(trap),
        .trap_cause(trap_cause), .state_o(state_o), .instret(instret)
    );

    // Second instance: no upper-immediate support and the dmem timeout disabled
    multicycle_controller #(.SUPPORT_UPPER(0), .MEM_TIMEOUT(0), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req2), .ir_write(ir_write2),
        .pc_write(pc_write2), .dmem_req(dmem_req2), .mem_read(mem_read2),
        .mem_write(mem_write2), .reg_write(reg_write2), .alu_src(alu_src2),
        .alu_src_a(alu_src_a2), .mem_to_reg(mem_to_reg2), .alu_op(alu_op2),
        .branch(branch2), .jump(jump2), .jumpr(jumpr2), .halt(halt2), .trap(trap2),
        .trap_cause(trap_cause2), .state_o(state_o2), .instret(instret2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        ctl_t e;
        reset      = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        tick();
        reset     = 1'b0;
        model_ret = 0;
        #1;
        e          = '0;
        e.imem_req = 1'b1;
        checkOutput("reset outputs", {11'd0, obs}, {11'd0, e});
        checkOutput("reset instret", {28'd0, instret}, 32'd0);
        checkOutput("reset trap_cause", {30'd0, trap_cause}, 32'd0);
        checkOutput("reset dut2 state", {29'd0, state_o2}, 32'd0);
    endtask

    // One instruction: fw imem wait cycles, dw dmem wait cycles, every cycle checked
    task automatic applyStimulus(input logic [6:0] op, input int fw, input int dw);
        ctl_t       e;
        logic       ex_src, ex_src_a, is_mem, has_wb, is_jmp;
        logic [1:0] ex_aop, wb_m2r;
        ex_src   = (op == OPC_LW) || (op == OPC_SW) || (op == OPC_IMM) || (op == OPC_JALR) || (op == OPC_AUIPC);
        ex_src_a = (op == OPC_AUIPC);
        ex_aop   = (op == OPC_BR) ? 2'b01 : (op == OPC_R) ? 2'b10 :
                   ((op == OPC_IMM) || (op == OPC_JALR)) ? 2'b11 : 2'b00;
        wb_m2r   = (op == OPC_LW) ? 2'b01 : (op == OPC_LUI) ? 2'b11 : 2'b00;
        is_mem   = (op == OPC_LW) || (op == OPC_SW);
        has_wb   = (op == OPC_LW) || (op == OPC_R) || (op == OPC_IMM) || (op == OPC_LUI) || (op == OPC_AUIPC);
        is_jmp   = (op == OPC_JAL) || (op == OPC_JALR);

        for (int w = 0; w <= fw; w++) begin
            imem_ready = (w == fw);
            dmem_ready = 1'($urandom_range(0, 1));
            opcode     = 7'($urandom);
            #1;
            e          = '0;
            e.imem_req = 1'b1;
            e.ir_write = imem_ready;
            e.pc_write = imem_ready;
            checkOutput($sformatf("fetch op=%b w=%0d", op, w), {11'd0, obs}, {11'd0, e});
            tick();
        end

        opcode     = op;
        imem_ready = 1'($urandom_range(0, 1));
        dmem_ready = 1'b0;
        #1;
        e    = '0;
        e.st = 3'd1;
        checkOutput($sformatf("decode op=%b", op), {11'd0, obs}, {11'd0, e});
        tick();

        opcode = 7'($urandom);
        #1;
        e           = '0;
        e.st        = 3'd2;
        e.alu_src   = ex_src;
        e.alu_src_a = ex_src_a;
        e.aop       = ex_aop;
        e.branch    = (op == OPC_BR);
        e.jump      = (op == OPC_JAL);
        e.jumpr     = (op == OPC_JALR);
        e.reg_write = is_jmp;
        e.m2r       = is_jmp ? 2'b10 : 2'b00;
        checkOutput($sformatf("exec op=%b", op), {11'd0, obs}, {11'd0, e});
        tick();

        if (is_mem) begin
            for (int w = 0; w <= dw; w++) begin
                dmem_ready = (w == dw);
                #1;
                e           = '0;
                e.st        = 3'd3;
                e.dmem_req  = 1'b1;
                e.mem_read  = (op == OPC_LW);
                e.mem_write = (op == OPC_SW);
                checkOutput($sformatf("mem op=%b w=%0d", op, w), {11'd0, obs}, {11'd0, e});
                tick();
            end
            dmem_ready = 1'b0;
        end

        if (has_wb) begin
            #1;
            e           = '0;
            e.st        = 3'd4;
            e.reg_write = 1'b1;
            e.m2r       = wb_m2r;
            e.alu_src   = ex_src;
            e.alu_src_a = ex_src_a;
            e.aop       = ex_aop;
            checkOutput($sformatf("wb op=%b", op), {11'd0, obs}, {11'd0, e});
            tick();
        end

        model_ret++;
        imem_ready = 1'b0;
        #1;
        checkOutput($sformatf("instret after op=%b", op), {28'd0, instret}, {28'd0, model_ret[3:0]});
        checkOutput("back to fetch", {29'd0, state_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetDut();

        // R-type, then a load whose ready lands on the last allowed wait cycle
        applyStimulus(OPC_R, 0, 0);
        applyStimulus(OPC_LW, 0, 3);

        applyStimulus(OPC_JAL, 0, 0);
        applyStimulus(OPC_BR, 0, 0);
        applyStimulus(OPC_JALR, 0, 0);
        checkOutput("instret after jal/br/jalr", {28'd0, instret}, 32'd5);

        applyStimulus(OPC_LUI, 0, 0);
        checkOutput("dut2 lui state", {29'd0, state_o2}, 32'd6);
        checkOutput("dut2 lui cause", {30'd0, trap_cause2}, 32'd1);
        checkOutput("dut2 lui halt/trap", {30'd0, halt2, trap2}, 32'd3);

        // Randomized stream; 4-bit counter wraps along the way
        for (int i = 0; i < 40; i++) begin
            applyStimulus(legal_ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Store that never completes: timeout after four MEM cycles
        resetDut();
        imem_ready = 1'b1;
        tick();
        opcode     = OPC_SW;
        imem_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("sw wait %0d state", i), {29'd0, state_o}, 32'd3);
            tick();
        end
        #1;
        checkOutput("timeout state", {29'd0, state_o}, 32'd6);
        checkOutput("timeout cause", {30'd0, trap_cause}, 32'd2);
        checkOutput("timeout halt/trap", {30'd0, halt, trap}, 32'd3);
        for (int i = 0; i < 20; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            opcode     = 7'($urandom);
            tick();
        end
        #1;
        checkOutput("timeout sticky state", {29'd0, state_o}, 32'd6);
        checkOutput("timeout sticky cause", {30'd0, trap_cause}, 32'd2);
        checkOutput("timeout sticky halt/trap/reqs", {28'd0, halt, trap, imem_req, dmem_req}, 32'd12);
        checkOutput("dut2 no timeout", {29'd0, state_o2}, 32'd3);

        // Unrecognised opcode traps from DECODE
        resetDut();
        imem_ready = 1'b1;
        tick();
        opcode     = 7'h7f;
        imem_ready = 1'b0;
        tick();
        #1;
        checkOutput("illegal state", {29'd0, state_o}, 32'd6);
        checkOutput("illegal cause", {30'd0, trap_cause}, 32'd1);
        checkOutput("illegal halt/trap", {30'd0, halt, trap}, 32'd3);

        // Halt opcode freezes everything, including instret
        resetDut();
        applyStimulus(OPC_R, 1, 0);
        imem_ready = 1'b1;
        tick();
        opcode = 7'b0000000;
        tick();
        for (int i = 0; i < 5; i++) tick();
        #1;
        checkOutput("halted state", {29'd0, state_o}, 32'd5);
        checkOutput("halted halt/trap/imem_req", {29'd0, halt, trap, imem_req}, 32'd4);
        checkOutput("halted instret", {28'd0, instret}, 32'd1);

        // Reset in the middle of a stalled load
        resetDut();
        applyStimulus(OPC_R, 0, 0);
        imem_ready = 1'b1;
        tick();
        opcode     = OPC_LW;
        imem_ready = 1'b0;
        tick();
        tick();
        tick();
        #1;
        checkOutput("mid-mem state", {29'd0, state_o}, 32'd3);
        resetDut();
        checkOutput("post-reset halt/trap", {30'd0, halt, trap}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor of the single-cycle main decoder.
- Sequences each RISC-V instruction through FETCH/DECODE/EXEC/MEM/WB with ready handshakes on instruction and data memory.
- Drives the same datapath controls as the single-cycle decoder, plus PC/IR write enables and memory requests.
- Adds optional LUI/AUIPC decode, an illegal-opcode trap, a data-memory timeout and a retired-instruction counter.

Parameters:
- SUPPORT_UPPER, 1, 1 decodes LUI (0110111) and AUIPC (0010111); 0 makes them illegal.
- MEM_TIMEOUT, 16, maximum dmem wait cycles before a bus-error trap; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the external IR; valid from DECODE onward.
- imem_ready  in  1  instruction memory has the word on this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC+4.
- dmem_req  out  1  data memory request.
- mem_read  out  1  load access.
- mem_write  out  1  store access.
- reg_write  out  1  register file write enable.
- alu_src  out  1  0 = rs2, 1 = immediate.
- alu_src_a  out  1  0 = rs1, 1 = PC (AUIPC).
- mem_to_reg  out  2  00 = ALU, 01 = memory, 10 = PC+4, 11 = immediate (LUI).
- alu_op  out  2  00 = add (ld/st/AUIPC/LUI), 01 = branch, 10 = R-type, 11 = I-type/JALR.
- branch  out  1  conditional PC update request.
- jump  out  1  JAL PC update.
- jumpr  out  1  JALR PC update.
- halt  out  1  sticky stop.
- trap  out  1  sticky fault.
- trap_cause  out  2  01 = illegal opcode, 10 = dmem timeout.
- state_o  out  3  current state encoding.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALTED = 5, TRAP = 6.
- Reset: state FETCH; opcode register, wait counter and instret cleared; halt, trap and trap_cause cleared.
  - All combinational outputs are 0 outside their state, except imem_req, which is 1 in FETCH.
  - Reset has priority over every transition, including mid-MEM and TRAP/HALTED.
- FETCH: imem_req = 1.
  - imem_ready = 1: ir_write = pc_write = 1 in the same cycle (Mealy), next state DECODE.
  - imem_ready = 0: remain in FETCH.
- DECODE: register opcode into op_q; no datapath enables. Next state:
  - 0000000 -> HALTED.
  - Unrecognised opcode, or LUI/AUIPC with SUPPORT_UPPER = 0 -> TRAP, cause 01.
  - Otherwise -> EXEC.
- EXEC: alu_op, alu_src and alu_src_a decoded from op_q.
  - alu_src = 1 for LW, SW, IMM, JALR, AUIPC.
  - alu_src_a = 1 for AUIPC only.
  - BR: branch = 1, retire, next FETCH.
  - JAL: jump = 1, reg_write = 1, mem_to_reg = 10, retire, next FETCH.
  - JALR: jumpr = 1, reg_write = 1, mem_to_reg = 10, alu_op = 11, retire, next FETCH.
  - LW/SW: next MEM, wait counter cleared.
  - R/IMM/LUI/AUIPC: next WB.
- MEM: dmem_req = 1; mem_read = 1 for LW, mem_write = 1 for SW.
  - dmem_ready = 1: SW retires and goes to FETCH; LW goes to WB.
  - dmem_ready = 0: counter increments.
  - MEM_TIMEOUT > 0 and counter == MEM_TIMEOUT-1 with no ready: next TRAP, cause 10.
  - Ready in the same cycle as the timeout wins: the access completes.
- WB: reg_write = 1, retire, next FETCH.
  - mem_to_reg = 01 for LW, 11 for LUI, 00 otherwise.
  - alu_src / alu_op / alu_src_a held per EXEC decode.
- HALTED: halt = 1, stays until reset; no requests; instret frozen.
- TRAP: trap = 1 and halt = 1; trap_cause held until reset.
- Retire: instret += 1 on the retiring cycle; wraps modulo 2^CNT_W, no saturation.
- Minimum latency, zero wait states: R-type 4 cycles; BR/JAL/JALR 3 cycles; LW 5 cycles; SW 4 cycles.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (R_TYPE, LW, SW, BR, IMM, JAL, JALR, LUI, AUIPC, HALT);
  - enum state_t with the encodings above;
  - ALUOp and MemtoReg localparam codes;
  - trap_cause codes.
- One sub-module, ctrl_decode: purely combinational op_q -> {alu_src, alu_src_a, alu_op, wb_sel, class flags, legal}. The FSM, counters and sticky flags stay in the top module.

Test Plan:
- Reset then R-type 0110011 with imem_ready = 1 constantly:
  - states 0,1,2,4,0;
  - reg_write = 1 only in WB with mem_to_reg = 00 and alu_op = 10;
  - instret = 1 after 4 cycles.
- LW 0000011 with dmem_ready low for 3 MEM cycles, then high:
  - mem_read = 1 and dmem_req = 1 for 4 cycles;
  - WB mem_to_reg = 01;
  - total 8 cycles; instret + 1.
- SW with dmem_ready never high and MEM_TIMEOUT = 4: after 4 MEM cycles, trap = 1, trap_cause = 10, halt = 1; stays after 20 more cycles.
- Sequence JAL 1101111, BR 1100011, JALR 1100111 (3 cycles each):
  - EXEC shows jump = 1/reg_write = 1/mem_to_reg = 10, then branch = 1/alu_op = 01, then jumpr = 1/alu_src = 1/alu_op = 11;
  - instret = 3.
- Opcode 0110111 (LUI):
  - SUPPORT_UPPER = 1: WB mem_to_reg = 11.
  - SUPPORT_UPPER = 0: DECODE -> TRAP with cause 01.
- Opcode 0000000 -> HALTED, halt = 1, no imem_req. Reset asserted mid-MEM: next cycle state FETCH, instret = 0, halt = trap = 0.
